// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I control sequencer.
// States, opcodes, mux-select encodings and the per-state control decode.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10,
      S_HALT     = 4'd11
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;

   typedef enum logic [1:0] {
      RES_ALUOUT = 2'b00,
      RES_DATA   = 2'b01,
      RES_ALU    = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_RS1   = 2'b10
   } alu_src_a_e;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } alu_src_b_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_e;

   // pc_write here is only the unconditional one; fetch/branch gate it later
   typedef struct packed {
      logic        mem_req;
      logic        mem_write;
      logic        adr_src;
      logic        pc_write;
      logic        reg_write;
      result_src_e result_src;
      alu_src_a_e  alu_src_a;
      alu_src_b_e  alu_src_b;
      alu_op_e     alu_op;
      logic        illegal;
   } ctl_t;

   function automatic ctl_t ctl_decode(state_e s);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req    = 1'b1;
            c.result_src = RES_ALU;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALU_ADD;
         end
         S_DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_MEMADR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_MEMREAD: begin
            c.mem_req    = 1'b1;
            c.adr_src    = 1'b1;
            c.result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.mem_req    = 1'b1;
            c.mem_write  = 1'b1;
            c.adr_src    = 1'b1;
            c.result_src = RES_ALUOUT;
         end
         S_EXECR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALU_FUNCT;
         end
         S_EXECI: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_JAL: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALU_ADD;
            c.result_src = RES_ALUOUT;
            c.pc_write   = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a  = SRCA_RS1;
            c.alu_src_b  = SRCB_RS2;
            c.alu_op     = ALU_SUB;
            c.result_src = RES_ALUOUT;
         end
         S_HALT: begin
            c.illegal = 1'b1;
         end
         default: begin
            c = '0;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_branch.sv
// Branch condition resolver for beq/bne/blt.
// Any other funct3 resolves as not taken.
module branch_resolve
   import mc_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       sign,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      unique case (funct3)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = !zero;
         F3_BLT:  taken = sign;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control sequencer for the multi-cycle RV32I core.
// Controls are registered alongside the state; only handshake gates are live.
module multicycle_ctrl_fsm
   import mc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        zero,
   input  logic        sign,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_write,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  imm_src,
   output logic        illegal,
   output logic [3:0]  state_dbg,
   output logic [31:0] instret
);

   state_e      state_q;
   state_e      state_d;
   ctl_t        ctl_q;
   logic [31:0] instret_q;
   logic        taken;
   logic        retire;
   logic        in_fetch;
   logic        in_branch;

   branch_resolve u_br (
      .funct3 (funct3),
      .zero   (zero),
      .sign   (sign),
      .taken  (taken)
   );

   always_comb begin
      state_d = S_FETCH;
      unique case (state_q)
         S_FETCH:
            state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            unique case (1'b1)
               (op == OP_LOAD),
               (op == OP_STORE):  state_d = S_MEMADR;
               (op == OP_RTYPE):  state_d = S_EXECR;
               (op == OP_ITYPE):  state_d = S_EXECI;
               (op == OP_JAL):    state_d = S_JAL;
               (op == OP_BRANCH): state_d = S_BRANCH;
               default:           state_d = S_HALT;
            endcase
         end
         S_MEMADR:
            state_d = (op == OP_LOAD) ? S_MEMREAD
                                      : S_MEMWRITE;
         S_MEMREAD:
            state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:
            state_d = S_FETCH;
         S_MEMWRITE:
            state_d = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR:
            state_d = S_ALUWB;
         S_EXECI:
            state_d = S_ALUWB;
         S_ALUWB:
            state_d = S_FETCH;
         S_JAL:
            state_d = S_ALUWB;
         S_BRANCH:
            state_d = S_FETCH;
         S_HALT:
            state_d = S_HALT;
         default:
            state_d = S_FETCH;
      endcase
   end

   // Entry to HALT never counts: only completed instructions retire
   always_comb begin
      retire = 1'b0;
      if (state_d == S_FETCH) begin
         retire = (state_q == S_MEMWB)
               || (state_q == S_MEMWRITE)
               || (state_q == S_ALUWB)
               || (state_q == S_BRANCH);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         ctl_q     <= ctl_decode(S_FETCH);
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_decode(state_d);
         if (retire) begin
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   always_comb begin
      imm_src = IMM_I;
      unique case (1'b1)
         (op == OP_STORE):  imm_src = IMM_S;
         (op == OP_BRANCH): imm_src = IMM_B;
         (op == OP_JAL):    imm_src = IMM_J;
         default:           imm_src = IMM_I;
      endcase
   end

   assign in_fetch  = (state_q == S_FETCH);
   assign in_branch = (state_q == S_BRANCH);

   assign mem_req    = ctl_q.mem_req;
   assign mem_write  = ctl_q.mem_write;
   assign adr_src    = ctl_q.adr_src;
   assign reg_write  = ctl_q.reg_write;
   assign result_src = ctl_q.result_src;
   assign alu_src_a  = ctl_q.alu_src_a;
   assign alu_src_b  = ctl_q.alu_src_b;
   assign alu_op     = ctl_q.alu_op;
   assign illegal    = ctl_q.illegal;
   assign ir_write   = in_fetch & mem_ready;
   assign pc_write   = ctl_q.pc_write
                     | (in_fetch & mem_ready)
                     | (in_branch & taken);
   assign state_dbg  = state_q;
   assign instret    = instret_q;

endmodule
